// File: rtl/alu_rr_sched_pkg.sv
// Shared definitions for the ALU round-robin scheduler: FSM encodings, widths and ALU op codes.
package alu_rr_sched_pkg;

  localparam int ALU_W   = 4;
  localparam int ALU_OPW = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Op codes understood by the shared ALU instance
  localparam logic [ALU_OPW-1:0] OP_ADD = 2'd0;
  localparam logic [ALU_OPW-1:0] OP_SUB = 2'd1;
  localparam logic [ALU_OPW-1:0] OP_AND = 2'd2;
  localparam logic [ALU_OPW-1:0] OP_OR  = 2'd3;

endpackage

// File: rtl/alu_rr_sched_rr_arb2.sv
// Two-way round-robin pick, purely combinational; the caller owns the 'last' register.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_sel,
  output logic any
);

  assign any = req0 | req1;
  // On a tie the requester that did not win last time goes next
  assign gnt_sel = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/alu_rr_sched.sv
// Shares one combinational ALU between two requesters: grant in IDLE, drive ALU in EXEC,
// return registered result with a done pulse in RESP (one op per three cycles).
module alu_rr_sched
  import alu_rr_sched_pkg::*;
#(
  parameter int W   = ALU_W,
  parameter int OPW = ALU_OPW
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           req0,
  input  logic           req1,
  input  logic [OPW-1:0] op0,
  input  logic [OPW-1:0] op1,
  input  logic           l0,
  input  logic           l1,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b0,
  input  logic [W-1:0]   b1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           done0,
  output logic           done1,
  output logic [W-1:0]   res_r,
  output logic           res_z,
  output logic           res_c,
  output logic           res_s,
  output logic           busy,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  output logic           alu_l,
  input  logic [W-1:0]   alu_r,
  input  logic           alu_z,
  input  logic           alu_c,
  input  logic           alu_s
);

  state_t state, state_nxt;
  logic   last;
  logic   gnt_sel;
  logic   any;
  logic   grant;

  rr_arb2 u_arb (
    .req0    (req0),
    .req1    (req1),
    .last    (last),
    .gnt_sel (gnt_sel),
    .any     (any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE: state_nxt = any ? ST_EXEC : ST_IDLE;
      ST_EXEC: state_nxt = ST_RESP;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // 'last' doubles as the owner of the op in flight, so done routes back from it
  always_comb begin
    grant = 1'b0;
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    done0 = 1'b0;
    done1 = 1'b0;
    busy  = 1'b0;
    case (state)
      ST_IDLE: begin
        grant = any;
        gnt0  = any & ~gnt_sel;
        gnt1  = any & gnt_sel;
      end
      ST_EXEC: busy = 1'b1;
      ST_RESP: begin
        busy  = 1'b1;
        done0 = ~last;
        done1 = last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last   <= 1'b1;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      alu_l  <= 1'b0;
      res_r  <= '0;
      res_z  <= 1'b0;
      res_c  <= 1'b0;
      res_s  <= 1'b0;
    end else begin
      if (grant) begin
        last   <= gnt_sel;
        alu_a  <= gnt_sel ? a1  : a0;
        alu_b  <= gnt_sel ? b1  : b0;
        alu_op <= gnt_sel ? op1 : op0;
        alu_l  <= gnt_sel ? l1  : l0;
      end
      if (state == ST_EXEC) begin
        res_r <= alu_r;
        res_z <= alu_z;
        res_c <= alu_c;
        res_s <= alu_s;
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Bench for alu_rr_sched: transaction model checked every cycle plus directed literal checks.
module tb_alu_rr_sched;

  logic       clk;
  logic       reset_n;
  logic       req0, req1;
  logic [1:0] op0, op1;
  logic       l0, l1;
  logic [3:0] a0, a1, b0, b1;
  logic       gnt0, gnt1, done0, done1;
  logic [3:0] res_r;
  logic       res_z, res_c, res_s;
  logic       busy;
  logic [3:0] alu_a, alu_b;
  logic [1:0] alu_op;
  logic       alu_l;
  logic [3:0] alu_r;
  logic       alu_z, alu_c, alu_s;

  int total = 0;
  int bad   = 0;
  int gnt_log[$];

  alu_rr_sched dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1), .l0(l0), .l1(l1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .res_r(res_r), .res_z(res_z), .res_c(res_c), .res_s(res_s), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_l(alu_l),
    .alu_r(alu_r), .alu_z(alu_z), .alu_c(alu_c), .alu_s(alu_s)
  );

  // ALU stub: R = A+B mod 16, c = carry-out
  always_comb begin
    {alu_c, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
    alu_z = (alu_r == 4'd0);
    alu_s = alu_r[3];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: an op is idle(0) -> executing(1) -> responding(2)
  int         m_phase;
  int         m_owner;
  int         m_prev;
  logic [3:0] m_a, m_b, m_r, p_r;
  logic [1:0] m_op;
  logic       m_l, m_z, m_c, m_s, p_z, p_c, p_s;

  always @(negedge clk) begin
    int       win;
    logic [4:0] sum;
    logic     e_g0, e_g1, e_d0, e_d1, e_busy;
    if (!reset_n) begin
      m_phase = 0; m_owner = 0; m_prev = 1;
      m_a = 0; m_b = 0; m_op = 0; m_l = 0;
      m_r = 0; m_z = 0; m_c = 0; m_s = 0;
    end
    win = -1;
    e_g0 = 0; e_g1 = 0; e_d0 = 0; e_d1 = 0; e_busy = 0;
    case (m_phase)
      0: if (req0 || req1) begin
           if (req0 && req1) win = (m_prev == 1) ? 0 : 1;
           else              win = req0 ? 0 : 1;
           e_g0 = (win == 0);
           e_g1 = (win == 1);
         end
      1: e_busy = 1;
      default: begin
        e_busy = 1;
        e_d0 = (m_owner == 0);
        e_d1 = (m_owner == 1);
      end
    endcase
    chk("gnt0", gnt0, e_g0);
    chk("gnt1", gnt1, e_g1);
    chk("done0", done0, e_d0);
    chk("done1", done1, e_d1);
    chk("busy", busy, e_busy);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_op", alu_op, m_op);
    chk("alu_l", alu_l, m_l);
    chk("res_r", res_r, m_r);
    chk("res_z", res_z, m_z);
    chk("res_c", res_c, m_c);
    chk("res_s", res_s, m_s);
    if (gnt0) gnt_log.push_back(0);
    if (gnt1) gnt_log.push_back(1);
    if (reset_n) begin
      case (m_phase)
        0: if (win >= 0) begin
             m_owner = win; m_prev = win;
             m_a  = (win == 1) ? a1 : a0;
             m_b  = (win == 1) ? b1 : b0;
             m_op = (win == 1) ? op1 : op0;
             m_l  = (win == 1) ? l1 : l0;
             sum  = {1'b0, m_a} + {1'b0, m_b};
             p_r = sum[3:0]; p_c = sum[4]; p_z = (sum[3:0] == 4'd0); p_s = sum[3];
             m_phase = 1;
           end
        1: begin
          m_r = p_r; m_z = p_z; m_c = p_c; m_s = p_s;
          m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset_n = 0; req0 = 0; req1 = 0;
    op0 = 0; op1 = 0; l0 = 0; l1 = 0; a0 = 0; a1 = 0; b0 = 0; b1 = 0;
    repeat (3) @(posedge clk);
    mid();
    chk("rst_busy", busy, 0);
    chk("rst_res_r", res_r, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_done0", done0, 0);
    cyc(); reset_n = 1;
    cyc();

    // 1: single requester, 7+11 -> 2 with carry
    a0 = 4'b0111; b0 = 4'b1011; op0 = 2'b10; l0 = 0; req0 = 1;
    mid(); chk("t1_gnt0", gnt0, 1); chk("t1_gnt1", gnt1, 0);
    cyc(); mid(); chk("t1_busy", busy, 1); chk("t1_alu_op", alu_op, 2'b10);
    chk("t1_alu_a", alu_a, 4'b0111); chk("t1_done0_early", done0, 0);
    cyc(); mid(); chk("t1_done0", done0, 1); chk("t1_res_r", res_r, 4'b0010);
    chk("t1_res_c", res_c, 1); chk("t1_res_z", res_z, 0); chk("t1_res_s", res_s, 0);
    req0 = 0;
    cyc(); cyc();

    // 2+4: simultaneous after reset, requester 1 computes 8+8
    reset_n = 0; cyc(); reset_n = 1; cyc();
    a0 = 4'd1; b0 = 4'd2; op0 = 2'd1; l0 = 1;
    a1 = 4'b1000; b1 = 4'b1000; op1 = 2'd3; l1 = 1;
    req0 = 1; req1 = 1;
    mid(); chk("t2_gnt0", gnt0, 1); chk("t2_gnt1", gnt1, 0);
    cyc(); cyc(); mid(); chk("t2_done0", done0, 1); chk("t2_res_r0", res_r, 4'd3);
    req0 = 0;
    cyc(); mid(); chk("t2_gnt1", gnt1, 1); chk("t2_gnt0_off", gnt0, 0);
    cyc(); mid(); chk("t2_alu_a", alu_a, 4'b1000); chk("t2_alu_op", alu_op, 2'd3);
    cyc(); mid(); chk("t4_done1", done1, 1); chk("t4_done0", done0, 0);
    chk("t4_res_r", res_r, 4'd0); chk("t4_res_z", res_z, 1);
    chk("t4_res_c", res_c, 1); chk("t4_res_s", res_s, 0);
    req1 = 0;
    cyc(); cyc(); mid(); chk("t4_hold_r", res_r, 4'd0); chk("t4_hold_z", res_z, 1);
    chk("t4_idle", busy, 0);

    // 3: both held high for eight grants
    gnt_log.delete();
    cyc(); req0 = 1; req1 = 1;
    repeat (23) cyc();
    mid(); req0 = 0; req1 = 0;
    cyc(); cyc();
    chk("t3_count", gnt_log.size(), 8);
    for (int i = 0; i < gnt_log.size() && i < 8; i++)
      chk("t3_order", gnt_log[i], i % 2);

    // 5: reset asserted in EXEC aborts, then requester 0 wins the first tie
    cyc(); a0 = 4'd5; b0 = 4'd5; req0 = 1;
    mid(); chk("t5_gnt0", gnt0, 1);
    cyc(); mid(); chk("t5_exec", busy, 1);
    reset_n = 0; req0 = 0;
    #1;
    chk("t5_busy", busy, 0); chk("t5_alu_a", alu_a, 0); chk("t5_res_r", res_r, 0);
    chk("t5_res_z", res_z, 0);
    cyc(); mid(); chk("t5_no_done", done0, 0);
    cyc(); reset_n = 1; req0 = 1; req1 = 1;
    mid(); chk("t5_tie_gnt0", gnt0, 1); chk("t5_tie_gnt1", gnt1, 0);
    cyc(); cyc(); mid(); chk("t5_done0", done0, 1); req0 = 0;
    cyc(); mid(); chk("t5_gnt1", gnt1, 1);
    cyc(); cyc(); mid(); chk("t5_done1", done1, 1); req1 = 0;

    // 6: req dropped after grant, operands changed; latched result still returned
    cyc(); a0 = 4'd3; b0 = 4'd4; req0 = 1;
    mid(); chk("t6_gnt0", gnt0, 1);
    cyc(); req0 = 0; a0 = 4'd15; b0 = 4'd15;
    mid(); chk("t6_alu_a", alu_a, 4'd3);
    cyc(); mid(); chk("t6_done0", done0, 1); chk("t6_res_r", res_r, 4'd7);
    chk("t6_res_c", res_c, 0);
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
